// File: rtl/agu_pipe.sv
// Pipelined address-generation unit: effective address / jump target, link value and
// alignment check, with a STAGES-deep valid/ready pipeline, flush and async reset.
module agu_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [1:0]       in_size,
  input  logic [XLEN-1:0]  in_base,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_addr,
  output logic [XLEN-1:0]  out_link,
  output logic             out_misaligned,
  output logic [1:0]       out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [1:0] ModeLoad  = 2'd0;
  localparam logic [1:0] ModeStore = 2'd1;
  localparam logic [1:0] ModeJal   = 2'd2;
  localparam logic [1:0] ModeJalr  = 2'd3;

  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_link;
  logic            w_jump;
  logic            w_mis;
  logic            w_unused;

  // Opcode bits never feed an immediate.
  assign w_unused = ^in_inst[6:0];

  always_comb begin
    w_imm = '0;
    case (in_mode)
      ModeLoad, ModeJalr: w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
      ModeStore:          w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      ModeJal:            w_imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                                   in_inst[20], in_inst[30:21], 1'b0};
      default:            w_imm = '0;
    endcase
  end

  assign w_jump = (in_mode == ModeJal) || (in_mode == ModeJalr);
  assign w_src  = (in_mode == ModeJal) ? in_pc : in_base;
  assign w_sum  = w_src + w_imm;
  assign w_addr = (in_mode == ModeJalr) ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
  assign w_link = w_jump ? (in_pc + XLEN'(4)) : '0;

  always_comb begin
    w_mis = 1'b0;
    if (w_jump) begin
      w_mis = w_addr[1];
    end else begin
      case (in_size)
        2'd0:    w_mis = 1'b0;
        2'd1:    w_mis = w_addr[0];
        default: w_mis = |w_addr[1:0];
      endcase
    end
  end

  logic [STAGES-1:0] r_valid;
  logic [XLEN-1:0]   r_addr [STAGES];
  logic [XLEN-1:0]   r_link [STAGES];
  logic [STAGES-1:0] r_mis;
  logic [1:0]        r_mode [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [STAGES-1:0] w_adv;

  // A stage advances when it is empty or everything downstream of it moves.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !r_valid[STAGES-1] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      w_adv[k] = !r_valid[k] || w_adv[k+1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_mis   <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        r_addr[k] <= '0;
        r_link[k] <= '0;
        r_mode[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else begin
        if (w_adv[0]) r_valid[0] <= in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
          if (w_adv[k]) r_valid[k] <= r_valid[k-1];
        end
      end
      // Payloads only move with a valid entry so idle stages keep their last contents.
      if (w_adv[0] && in_valid) begin
        r_addr[0] <= w_addr;
        r_link[0] <= w_link;
        r_mis[0]  <= w_mis;
        r_mode[0] <= in_mode;
        r_tag[0]  <= in_tag;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (w_adv[k] && r_valid[k-1]) begin
          r_addr[k] <= r_addr[k-1];
          r_link[k] <= r_link[k-1];
          r_mis[k]  <= r_mis[k-1];
          r_mode[k] <= r_mode[k-1];
          r_tag[k]  <= r_tag[k-1];
        end
      end
    end
  end

  assign in_ready       = w_adv[0];
  assign busy           = |r_valid;
  assign out_valid      = r_valid[STAGES-1];
  assign out_addr       = r_addr[STAGES-1];
  assign out_link       = r_link[STAGES-1];
  assign out_misaligned = r_mis[STAGES-1];
  assign out_mode       = r_mode[STAGES-1];
  assign out_tag        = r_tag[STAGES-1];

endmodule

// File: tb/tb_agu_pipe.sv
// Directed bench for agu_pipe: vector table on a 2-stage unit, backpressure, flush,
// mid-cycle reset and latency checks on 1-, 2- and 4-stage instances.
module tb_agu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  in_mode = '0;
  logic [1:0]  in_size = '0;
  logic [31:0] in_base = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic [5:0]  in_tag = '0;

  logic        o1_in_ready, o1_valid, o1_mis, o1_busy;
  logic [31:0] o1_addr, o1_link;
  logic [1:0]  o1_mode;
  logic [5:0]  o1_tag;
  logic        o2_in_ready, o2_valid, o2_mis, o2_busy;
  logic [31:0] o2_addr, o2_link;
  logic [1:0]  o2_mode;
  logic [5:0]  o2_tag;
  logic        o4_in_ready, o4_valid, o4_mis, o4_busy;
  logic [31:0] o4_addr, o4_link;
  logic [1:0]  o4_mode;
  logic [5:0]  o4_tag;

  always #5 clk = ~clk;

  agu_pipe #(.XLEN(32), .STAGES(1), .TAG_W(6)) u_dut1 (
    .clock(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_mode(in_mode), .in_size(in_size), .in_base(in_base), .in_pc(in_pc),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(o1_valid), .out_ready(out_ready),
    .out_addr(o1_addr), .out_link(o1_link), .out_misaligned(o1_mis), .out_mode(o1_mode),
    .out_tag(o1_tag), .busy(o1_busy)
  );

  agu_pipe #(.XLEN(32), .STAGES(2), .TAG_W(6)) u_dut2 (
    .clock(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(o2_in_ready),
    .in_mode(in_mode), .in_size(in_size), .in_base(in_base), .in_pc(in_pc),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(o2_valid), .out_ready(out_ready),
    .out_addr(o2_addr), .out_link(o2_link), .out_misaligned(o2_mis), .out_mode(o2_mode),
    .out_tag(o2_tag), .busy(o2_busy)
  );

  agu_pipe #(.XLEN(32), .STAGES(4), .TAG_W(6)) u_dut4 (
    .clock(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(o4_in_ready),
    .in_mode(in_mode), .in_size(in_size), .in_base(in_base), .in_pc(in_pc),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(o4_valid), .out_ready(out_ready),
    .out_addr(o4_addr), .out_link(o4_link), .out_misaligned(o4_mis), .out_mode(o4_mode),
    .out_tag(o4_tag), .busy(o4_busy)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  size;
    logic [31:0] base;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  tag;
    logic [31:0] addr;
    logic [31:0] link;
    logic        mis;
  } vec_t;

  vec_t vecs[12];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input logic [1:0] size, input logic [31:0] base,
                       input logic [31:0] pc, input logic [31:0] inst, input logic [5:0] tag);
    in_valid = 1'b1;
    in_mode  = mode;
    in_size  = size;
    in_base  = base;
    in_pc    = pc;
    in_inst  = inst;
    in_tag   = tag;
  endtask

  task automatic chk_zero2(input string nm);
    chk({nm, " valid"}, 64'(o2_valid), 64'd0);
    chk({nm, " addr"},  64'(o2_addr),  64'd0);
    chk({nm, " link"},  64'(o2_link),  64'd0);
    chk({nm, " mis"},   64'(o2_mis),   64'd0);
    chk({nm, " mode"},  64'(o2_mode),  64'd0);
    chk({nm, " tag"},   64'(o2_tag),   64'd0);
    chk({nm, " busy"},  64'(o2_busy),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, rcvd, occ, stalls;
    logic in_x, out_x;

    vecs[0]  = '{2'd0, 2'd2, 32'h0000_1000, 32'h0,         32'hFFC0_0003, 6'd1,
                 32'h0000_0FFC, 32'h0,         1'b0};
    vecs[1]  = '{2'd1, 2'd1, 32'h0000_2001, 32'h0,         32'h0000_0080, 6'd2,
                 32'h0000_2002, 32'h0,         1'b0};
    vecs[2]  = '{2'd1, 2'd2, 32'h0000_2001, 32'h0,         32'h0000_0080, 6'd3,
                 32'h0000_2002, 32'h0,         1'b1};
    vecs[3]  = '{2'd2, 2'd0, 32'h1234_5678, 32'h0000_0400, 32'h0010_0000, 6'd4,
                 32'h0000_0C00, 32'h0000_0404, 1'b0};
    vecs[4]  = '{2'd3, 2'd0, 32'h0000_3003, 32'h0000_0100, 32'h0000_0000, 6'd5,
                 32'h0000_3002, 32'h0000_0104, 1'b1};
    vecs[5]  = '{2'd0, 2'd0, 32'h0000_0003, 32'h0,         32'h0000_0000, 6'd6,
                 32'h0000_0003, 32'h0,         1'b0};
    vecs[6]  = '{2'd0, 2'd1, 32'h0000_0003, 32'h0,         32'h0000_0000, 6'd7,
                 32'h0000_0003, 32'h0,         1'b1};
    vecs[7]  = '{2'd0, 2'd3, 32'h0000_0002, 32'h0,         32'h0000_0000, 6'd8,
                 32'h0000_0002, 32'h0,         1'b1};
    vecs[8]  = '{2'd2, 2'd2, 32'h0,         32'h0000_1000, 32'hFFFF_F000, 6'd9,
                 32'h0000_0FFE, 32'h0000_1004, 1'b1};
    vecs[9]  = '{2'd3, 2'd2, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0010_0000, 6'd10,
                 32'h0000_1000, 32'h0,         1'b0};
    vecs[10] = '{2'd0, 2'd0, 32'hFFFF_FFFF, 32'h0,         32'h0010_0000, 6'd11,
                 32'h0000_0000, 32'h0,         1'b0};
    vecs[11] = '{2'd1, 2'd1, 32'h0000_0100, 32'h0,         32'hFE00_0F80, 6'd12,
                 32'h0000_00FF, 32'h0,         1'b1};

    // Reset state
    #1 rst = 1'b1;
    #2 chk_zero2("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset in_ready", 64'(o2_in_ready), 64'd1);

    // Vector table, one entry at a time
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].mode, vecs[i].size, vecs[i].base, vecs[i].pc, vecs[i].inst, vecs[i].tag);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d early valid", i), 64'(o2_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d valid", i), 64'(o2_valid), 64'd1);
      chk($sformatf("v%0d addr", i),  64'(o2_addr),  64'(vecs[i].addr));
      chk($sformatf("v%0d link", i),  64'(o2_link),  64'(vecs[i].link));
      chk($sformatf("v%0d mis", i),   64'(o2_mis),   64'(vecs[i].mis));
      chk($sformatf("v%0d mode", i),  64'(o2_mode),  64'(vecs[i].mode));
      chk($sformatf("v%0d tag", i),   64'(o2_tag),   64'(vecs[i].tag));
    end

    // Backpressure: 6 back-to-back loads, out_ready low for 3 cycles
    sent = 0; rcvd = 0; occ = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) drive(2'd0, 2'd2, 32'(sent * 64), 32'h0, 32'h0, 6'(16 + sent));
      else in_valid = 1'b0;
      #1;
      chk($sformatf("bp in_ready c%0d", cyc), 64'(o2_in_ready),
          64'((occ < 2) || out_ready));
      chk($sformatf("bp busy c%0d", cyc), 64'(o2_busy), 64'(occ != 0));
      if (!o2_in_ready) stalls++;
      if (o2_valid) begin
        chk($sformatf("bp tag c%0d", cyc),  64'(o2_tag),  64'(16 + rcvd));
        chk($sformatf("bp addr c%0d", cyc), 64'(o2_addr), 64'(rcvd * 64));
      end
      in_x  = in_valid && o2_in_ready;
      out_x = o2_valid && out_ready;
      if (in_x) sent++;
      if (out_x) rcvd++;
      occ = occ + int'(in_x) - int'(out_x);
    end
    chk("bp received", 64'(rcvd), 64'd6);
    chk("bp stalled", 64'(stalls != 0), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Flush with the pipeline full and an entry offered
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'd0, 2'd2, 32'h100, 32'h0, 32'h0, 6'h20);
    @(negedge clk);
    drive(2'd0, 2'd2, 32'h200, 32'h0, 32'h0, 6'h21);
    @(negedge clk);
    chk("full in_ready", 64'(o2_in_ready), 64'd0);
    chk("full busy", 64'(o2_busy), 64'd1);
    chk("full head tag", 64'(o2_tag), 64'h20);
    drive(2'd0, 2'd2, 32'h300, 32'h0, 32'h0, 6'h22);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("flush valid", 64'(o2_valid), 64'd0);
    chk("flush busy", 64'(o2_busy), 64'd0);
    chk("flush in_ready", 64'(o2_in_ready), 64'd1);
    // Flush on an empty pipe while an entry is accepted
    @(negedge clk);
    drive(2'd0, 2'd2, 32'h400, 32'h0, 32'h0, 6'h23);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("post-flush valid c%0d", c), 64'(o2_valid), 64'd0);
      chk($sformatf("post-flush busy c%0d", c), 64'(o2_busy), 64'd0);
      @(negedge clk);
    end

    // Reset asserted between edges mid-stream
    drive(2'd0, 2'd2, 32'h500, 32'h0, 32'h0, 6'h30);
    @(negedge clk);
    drive(2'd0, 2'd2, 32'h600, 32'h0, 32'h0, 6'h31);
    @(negedge clk);
    drive(2'd0, 2'd2, 32'h700, 32'h0, 32'h0, 6'h32);
    chk("pre-reset valid", 64'(o2_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_zero2("mid reset");
    chk("mid reset s1 valid", 64'(o1_valid), 64'd0);
    chk("mid reset s4 busy", 64'(o4_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel in_ready s1", 64'(o1_in_ready), 64'd1);
    chk("rel in_ready s2", 64'(o2_in_ready), 64'd1);
    chk("rel in_ready s4", 64'(o4_in_ready), 64'd1);

    // Latency at STAGES = 1, 2, 4
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      if (j == 0) drive(2'd0, 2'd2, 32'hFFFF_FFFF, 32'h0, 32'h0010_0000, 6'h3A);
      else drive(2'd0, 2'd2, 32'h0000_1000, 32'h0, 32'hFFC0_0003, 6'h3B);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("lat%0d s1 valid", j), 64'(o1_valid), 64'd1);
      chk($sformatf("lat%0d s1 addr", j), 64'(o1_addr), (j == 0) ? 64'h0 : 64'hFFC);
      chk($sformatf("lat%0d s2 early", j), 64'(o2_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("lat%0d s2 valid", j), 64'(o2_valid), 64'd1);
      chk($sformatf("lat%0d s2 addr", j), 64'(o2_addr), (j == 0) ? 64'h0 : 64'hFFC);
      @(negedge clk);
      chk($sformatf("lat%0d s4 early", j), 64'(o4_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("lat%0d s4 valid", j), 64'(o4_valid), 64'd1);
      chk($sformatf("lat%0d s4 addr", j), 64'(o4_addr), (j == 0) ? 64'h0 : 64'hFFC);
      chk($sformatf("lat%0d s4 tag", j), 64'(o4_tag), (j == 0) ? 64'h3A : 64'h3B);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/agu_pipe.md
Name: agu_pipe

Overview:
Parametrised, pipelined address-generation unit. It is the successor to the single-stage address calculator in the execute stage. It computes effective addresses for loads/stores and targets for JAL/JALR, adds a link value, size-aware misalignment detection, a valid/ready handshake with per-stage backpressure, and a flush. It sits between the load/store/branch issue ports and the memory/branch-resolution units.

Parameters:
XLEN, 32, datapath width of base, PC, address and link.
STAGES, 2, pipeline depth 1..4; result latency in cycles.
TAG_W, 6, width of the destination/ROB tag carried alongside.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all in-flight entries
in_valid  in  1  input entry valid
in_ready  out  1  unit can accept an entry this cycle
in_mode  in  2  0=LOAD, 1=STORE, 2=JAL, 3=JALR
in_size  in  2  0=byte, 1=half, 2=word; ignored for jumps
in_base  in  XLEN  rs1 value
in_pc  in  XLEN  instruction PC
in_inst  in  32  raw instruction, source of the immediate
in_tag  in  TAG_W  tag passed through
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_addr  out  XLEN  effective address / jump target
out_link  out  XLEN  PC+4 for jumps, 0 otherwise
out_misaligned  out  1  address violates alignment
out_mode  out  2  mode passed through
out_tag  out  TAG_W  tag passed through
busy  out  1  any stage holds a valid entry

Behaviour:
- Immediate: LOAD/JALR use sign-extended I-imm inst[31:20]. STORE uses sign-extended S-imm {inst[31:25],inst[11:7]}. JAL uses sign-extended J-imm {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
- Base: in_pc for JAL, in_base otherwise. Sum is truncated modulo 2^XLEN. JALR clears bit 0 of the sum.
- Misalignment: half requires addr[0]=0; word requires addr[1:0]=0; byte is never misaligned. Jumps are misaligned if target[1]=1, checked after JALR bit-0 clear. in_size=3 is treated as word.
- out_link = in_pc+4 (mod 2^XLEN) for JAL/JALR, 0 for LOAD/STORE.
- Computation is combinational on the input side. The result is captured into stage 0, then shifted through the remaining STAGES-1 registers. Outputs are driven from the last stage.
- Latency: an entry accepted at edge N is presented with out_valid at edge N+STAGES-1 (visible in the cycle after N+STAGES-1), given no backpressure.
- Handshake: the last stage advances when out_ready or !out_valid. Stage k advances when stage k+1 is empty or advancing. in_ready equals "stage 0 is empty or advancing", i.e. it is combinational from out_ready with no bubbles. Throughput is 1 entry/cycle.
- Transfers: an input transfer occurs on in_valid&&in_ready; an output transfer on out_valid&&out_ready. Held outputs remain stable while out_valid&&!out_ready.
- in_valid with in_ready=0 is not consumed; the source must hold it.
- flush: at the next edge all stage valids clear, and any entry presented that cycle is discarded. in_ready is 1 in the cycle after a flush. flush has priority over simultaneous accept/shift.
- Reset (async, any time, including mid-operation): all stage valids and payloads go to 0. out_valid=0, out_addr=0, out_link=0, out_misaligned=0, out_mode=0, out_tag=0, busy=0. in_ready=1 once reset deasserts.
- busy = OR of stage valids.
- Full: with all STAGES valid and out_ready=0, in_ready=0 and nothing is overwritten.

Test Plan:
- LOAD base=0x1000, inst imm=-4 (0xFFC), size=word, STAGES=2 -> out_valid two cycles after accept, addr=0x0FFC, misaligned=0, link=0, tag echoed.
- STORE base=0x2001, S-imm=+1, size=half -> addr=0x2002, misaligned=0. Same entry with size=word -> misaligned=1.
- JAL pc=0x400, J-imm=+0x800 -> addr=0xC00, link=0x404. JALR base=0x3003, imm=0 -> addr=0x3002, misaligned=1.
- Backpressure: stream 6 back-to-back LOADs, hold out_ready=0 for 3 cycles mid-stream -> in_ready drops after STAGES entries fill; all 6 exit in order, none dropped or duplicated, outputs stable while held.
- flush with pipeline full, simultaneous in_valid -> next cycle out_valid=0, busy=0, in_ready=1; the flushed entries never appear.
- Assert reset mid-stream between clock edges -> outputs immediately 0. After release, a new LOAD completes with the correct address; also repeat at STAGES=1 and STAGES=4, and base=0xFFFFFFFF, imm=+1 -> addr=0x00000000.
